// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built on one full-adder cell
//
// Purpose:
//    Accepts two WIDTH-bit operands plus carry-in and ripples them LSB-first
//    through a single full-adder cell, one bit per clock. The parallel sum and
//    carry-out are then presented until the consumer takes them.
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_valid   operands a, b, cin (and sub) valid
//    in_ready   block can accept operands (IDLE)
//    a, b       WIDTH-bit operands
//    cin        carry-in to bit 0
//    sub        subtract request (only honoured with SERIAL_ADDER_SUB_EN)
//    out_valid  sum and cout valid (DONE)
//    out_ready  consumer accepts the result
//    sum        WIDTH-bit result
//    cout       carry out of bit WIDTH-1
//    busy       high in RUN or DONE
//
// Configuration:
//    SERIAL_ADDER_SUB_EN  when defined, sub=1 at acceptance computes a-b
//                         (cout=1 means no borrow); otherwise sub is ignored.

module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             c_q,      c_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic             cout_q,   cout_d;

   // The single full-adder cell, fed from the LSBs of the shift registers.
   logic fa_s;
   logic fa_c;
   assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
   assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

`ifndef SERIAL_ADDER_SUB_EN
   logic sub_unused;
   assign sub_unused = sub;
`endif

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d   = a;
               b_sh_d   = b;
               c_d      = cin;
               cnt_d    = '0;
               sum_sh_d = '0;
`ifdef SERIAL_ADDER_SUB_EN
               // Two's-complement subtract: a + ~b + 1.
               if (sub) begin
                  b_sh_d = ~b;
                  c_d    = 1'b1;
               end
`endif
               state_d  = RUN;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            c_d      = fa_c;
            // Last bit: publish the completed word; the counter stops here.
            if (cnt_q == LAST_BIT) begin
               sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
               cout_d  = fa_c;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=4)

module tb_serial_adder;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // Reference model: an operation occupies the block for W edges after
   // acceptance, then holds its result until out_ready is seen on an edge.
   // m_rem: -1 idle, >0 edges still to go, 0 result on offer.
   int           m_rem = -1;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0;
   logic [W-1:0] p_sum;
   logic         p_cout;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem  = -1;
         m_sum  = '0;
         m_cout = 1'b0;
      end else if (m_rem == 0) begin
         if (out_ready) m_rem = -1;
      end else if (m_rem > 0) begin
         m_rem = m_rem - 1;
         if (m_rem == 0) begin
            m_sum  = p_sum;
            m_cout = p_cout;
         end
      end else if (in_valid) begin
         int ai, bi, r;
         ai = int'(a);
         bi = int'(b);
`ifdef SERIAL_ADDER_SUB_EN
         if (sub) begin
            r = (ai - bi + 16) % 16;
            p_sum  = W'(r);
            p_cout = (ai >= bi);
         end else begin
            r = ai + bi + int'(cin);
            p_sum  = W'(r % 16);
            p_cout = (r >= 16);
         end
`else
         r = ai + bi + int'(cin);
         p_sum  = W'(r % 16);
         p_cout = (r >= 16);
`endif
         m_rem = W;
      end
   end

   logic cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         check("in_ready",  int'(in_ready),  int'(m_rem < 0));
         check("out_valid", int'(out_valid), int'(m_rem == 0));
         check("busy",      int'(busy),      int'(m_rem >= 0));
         check("sum",       int'(sum),       int'(m_sum));
         check("cout",      int'(cout),      int'(m_cout));
      end
   end

   // Present operands at a negedge; leaves the bench at the first negedge after acceptance.
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
      @(negedge clk);
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Called at the first negedge after acceptance; counts edges to out_valid.
   task automatic wait_done(input string name, input int exp_sum, input int exp_cout);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({name, "_latency"}, lat, W);
      check({name, "_sum"}, int'(sum), exp_sum);
      check({name, "_cout"}, int'(cout), exp_cout);
   endtask

   task automatic release_result(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_idle"}, int'(in_ready), 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready",  int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_busy",      int'(busy), 0);
      check("reset_sum",       int'(sum), 0);
      check("reset_cout",      int'(cout), 0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      start_op(4'd5, 4'd3, 1'b0, 1'b0);
      wait_done("add_5_3", 8, 0);
      release_result("add_5_3");

      // out_ready high in IDLE and throughout RUN must change nothing early.
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      start_op(4'd15, 4'd1, 1'b0, 1'b0);
      check("run_busy_with_out_ready", int'(busy), 1);
      wait_done("add_15_1", 0, 1);
      release_result("add_15_1");

      start_op(4'd15, 4'd15, 1'b1, 1'b0);
      wait_done("add_15_15_1", 15, 1);
      release_result("add_15_15_1");

      // in_valid kept high with a=9 during RUN/DONE: only taken once IDLE.
      start_op(4'd0, 4'd0, 1'b0, 1'b0);
      a = 4'd9; b = 4'd0; cin = 1'b0; in_valid = 1'b1;
      wait_done("add_0_0", 0, 0);
      release_result("add_0_0");
      @(negedge clk);
      in_valid = 1'b0;
      check("held_accept_busy", int'(busy), 1);
      wait_done("held_9", 9, 0);
      release_result("held_9");

      // Backpressure: result must sit still while out_ready is low.
      start_op(4'd6, 4'd7, 1'b1, 1'b0);
      wait_done("bp_6_7_1", 14, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_sum", int'(sum), 14);
      end
      release_result("bp");

      // Asynchronous reset in the middle of RUN.
      start_op(4'd10, 4'd5, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_in_ready",  int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy",      int'(busy), 0);
      check("rst_sum",       int'(sum), 0);
      check("rst_cout",      int'(cout), 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_op(4'd2, 4'd2, 1'b0, 1'b0);
      wait_done("add_2_2", 4, 0);
      release_result("add_2_2");

`ifdef SERIAL_ADDER_SUB_EN
      start_op(4'd7, 4'd3, 1'b0, 1'b1);
      wait_done("sub_7_3", 4, 1);
      release_result("sub_7_3");
      start_op(4'd3, 4'd7, 1'b0, 1'b1);
      wait_done("sub_3_7", 12, 0);
      release_result("sub_3_7");
`else
      start_op(4'd7, 4'd3, 1'b0, 1'b1);
      wait_done("sub_ignored_7_3", 10, 0);
      release_result("sub_ignored_7_3");
`endif
      sub = 1'b0;

      repeat (2) @(negedge clk);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
